// File: rtl/fifo_stream_drain_pkg.sv
// fifo_stream_drain_pkg: shared word width and word type for the fifo drain
package fifo_stream_drain_pkg;
  localparam int DW = 32;
  typedef logic [DW-1:0] word_t;
endpackage

// File: rtl/fifo_stream_drain_if.sv
// fifo_stream_drain_if: valid/ready word stream
interface fifo_stream_drain_if;
  import fifo_stream_drain_pkg::*;
  logic valid;
  logic ready;
  word_t data;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/fifo_stream_drain_skid_buf.sv
// fifo_stream_drain_skid_buf: 2-entry circular buffer absorbing the fifo read latency
module fifo_stream_drain_skid_buf
  import fifo_stream_drain_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       wr_en,
  input  word_t      wr_data,
  input  logic       rd_en,
  output word_t      rd_data,
  output logic [1:0] occ
);
  word_t mem [2];
  logic head, tail;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      occ  <= '0;
      head <= 1'b0;
      tail <= 1'b0;
    end else begin
      occ  <= occ + {1'b0, wr_en} - {1'b0, rd_en};
      head <= head ^ rd_en;
      tail <= tail ^ wr_en;
    end
  end
  always_ff @(posedge clk)
    if (wr_en) mem[tail] <= wr_data;
  // Empty buffer shows zero so the stream data is defined out of reset
  always_comb rd_data = (occ != 2'd0) ? mem[head] : '0;
endmodule

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: pops a latency-1 fifo and presents its words on a valid/ready stream
module fifo_stream_drain
  import fifo_stream_drain_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  word_t                fifo_dout,
  output logic                 fifo_pop,
  input  logic                 flush,
  output logic [CW-1:0]        word_cnt,
  output logic                 busy,
  fifo_stream_drain_if.master  m
);
  logic inflight, accept;
  logic [1:0] occ;
  word_t head_data;
  fifo_stream_drain_skid_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .wr_en   (inflight),
    .wr_data (fifo_dout),
    .rd_en   (accept),
    .rd_data (head_data),
    .occ     (occ)
  );
  // Pop only while the buffer plus the word in flight leaves room after this cycle's accept
  always_comb begin
    m.valid  = occ != 2'd0;
    m.data   = head_data;
    accept   = m.valid && m.ready;
    busy     = m.valid || inflight;
    fifo_pop = !fifo_empty && !flush && !rst &&
               ({1'b0, occ} + {2'b0, inflight} - {2'b0, accept} < 3'd2);
  end
  always_ff @(posedge clk) begin
    inflight <= !rst && fifo_pop;
    word_cnt <= rst ? '0 : word_cnt + CW'(accept);
  end
endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb_fifo_stream_drain: queue-modelled fifo source with a scoreboard checking the drained stream
module tb_fifo_stream_drain;
  import fifo_stream_drain_pkg::*;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic fifo_empty, fifo_pop, busy, pop4, busy4;
  word_t fifo_dout = '0;
  logic [15:0] word_cnt;
  logic [3:0] cnt4;
  int checks = 0, errors = 0, pops = 0;
  word_t src_q[$], exp_q[$];
  fifo_stream_drain_if m();
  fifo_stream_drain_if m4();
  assign m4.ready = m.ready;
  assign fifo_empty = src_q.size() == 0;
  fifo_stream_drain dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_pop(fifo_pop),
    .flush(flush), .word_cnt(word_cnt), .busy(busy), .m(m)
  );
  fifo_stream_drain #(.CW(4)) dut4 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_pop(pop4),
    .flush(flush), .word_cnt(cnt4), .busy(busy4), .m(m4)
  );
  always #5 clk = ~clk;
  // Source fifo model: read data appears the cycle after a pop
  always @(posedge clk)
    if (fifo_pop && src_q.size() != 0) begin
      fifo_dout <= src_q.pop_front();
      pops++;
    end
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask
  // Scoreboard monitor: every accepted word must be the oldest outstanding one
  always @(negedge clk) begin
    word_t e;
    if (!rst) begin
      chk("pop_on_empty", {31'b0, fifo_empty && fifo_pop}, 0);
      if (m.valid && m.ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", m.data, 32'hdeadbeef);
        else begin
          e = exp_q.pop_front();
          chk("stream_data", m.data, e);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(word_t w);
    src_q.push_back(w);
    exp_q.push_back(w);
  endtask
  task automatic collect(int n, string name);
    int first = -1, last = -1, got = 0;
    for (int t = 0; t < 200 && got < n; t++) begin
      if (m.valid && m.ready) begin
        if (first < 0) first = t;
        last = t;
        got++;
      end
      tick();
    end
    chk({name, "_count"}, got, n);
    chk({name, "_gapless"}, last - first, n - 1);
  endtask
  initial begin
    int p0;
    logic held;
    m.ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", m.valid, 0);
    chk("rst_pop", fifo_pop, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt4", cnt4, 0);
    m.ready = 1'b1;
    push(32'h10);
    #1;
    chk("single_pop", fifo_pop, 1);
    tick();
    chk("single_n1_valid", m.valid, 0);
    tick();
    chk("single_n2_valid", m.valid, 1);
    chk("single_n2_data", m.data, 32'h10);
    tick();
    chk("single_cnt", word_cnt, 1);
    chk("single_busy", busy, 0);
    for (int i = 0; i < 16; i++) push(32'h10 + i);
    collect(16, "stream");
    tick();
    chk("stream_cnt", word_cnt, 17);
    chk("wrap_cnt4", cnt4, 1);
    m.ready = 1'b0;
    p0 = pops;
    held = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h10 + i);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 2 && m.data !== 32'h10) held = 1'b0;
    end
    chk("bp_pops", pops - p0, 2);
    chk("bp_held", held, 1);
    chk("bp_valid", m.valid, 1);
    m.ready = 1'b1;
    collect(4, "bp");
    tick();
    chk("bp_cnt", word_cnt, 21);
    m.ready = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h30 + i);
    repeat (5) tick();
    m.ready = 1'b1;
    tick();
    m.ready = 1'b0;
    flush = 1'b1;
    exp_q.delete();
    push(32'h20);
    #1;
    chk("flush_busy_before", busy, 1);
    chk("flush_no_pop", fifo_pop, 0);
    tick();
    flush = 1'b0;
    chk("flush_valid", m.valid, 0);
    chk("flush_busy", busy, 0);
    m.ready = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick();
    chk("flush_next_done", exp_q.size(), 0);
    tick();
    chk("flush_cnt", word_cnt, 23);
    for (int n = 0, t = 0; (n < 1000 || exp_q.size() != 0) && t < 20000; t++) begin
      m.ready = 1'($urandom_range(0, 1));
      if (n < 1000 && $urandom_range(0, 2) != 0) begin
        push($urandom);
        n++;
      end
      tick();
    end
    m.ready = 1'b1;
    repeat (4) tick();
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_cnt", word_cnt, 1023);
    chk("rand_cnt4", cnt4, 1023 % 16);
    chk("rand_idle", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
